// File: rtl/nbr_averager.sv
// nbr_averager: neighbor-weighted vertex smoothing over three single-port RAMs.
// For every vertex v it produces, per coordinate c,
//    res_c = sum_k (nbr_c >>> beta_shift) + trunc((cur_c * w) >>> FRAC_BITS)
//    w     = one - ((n << FRAC_BITS) >>> beta_shift)
// The neighbor count n is clamped to MAX_NEIGHBOR_COUNT-1. When clamping
// happens, the sticky err_nbr_ovf flag is set.
// Per-vertex latency, exact:
//    2 + n*(COORD_COUNT+2) + (COORD_COUNT+1) + COORD_COUNT cycles.
// Each pass ends with one extra DONE cycle.
`timescale 1ns/1ps
module nbr_averager #(
   parameter int ADDR_WIDTH         = 9,
   parameter int DATA_WIDTH         = 32,
   parameter int FRAC_BITS          = 16,
   parameter int COORD_COUNT        = 3,
   parameter int MAX_NEIGHBOR_COUNT = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] vertex_count,
   input  logic [3:0]            beta_shift,
   output logic                  RAM_OBJ_EN,
   output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
   input  logic [DATA_WIDTH-1:0] RAM_OBJ_Do,
   output logic                  RAM_NBR_EN,
   output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
   input  logic [DATA_WIDTH-1:0] RAM_NBR_Do,
   output logic                  RAM_RES_EN,
   output logic [3:0]            RAM_RES_WE,
   output logic [ADDR_WIDTH-1:0] RAM_RES_A,
   output logic [DATA_WIDTH-1:0] RAM_RES_Di,
   output logic                  busy,
   output logic                  done,
   output logic                  err_nbr_ovf
);

   localparam int ACC_W  = DATA_WIDTH + 4;
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int NW     = $clog2(MAX_NEIGHBOR_COUNT) + 1;
   localparam int PW     = 3;

   localparam logic [NW-1:0] N_CAP      = NW'(MAX_NEIGHBOR_COUNT - 1);
   localparam logic [PW-1:0] PH_LAST    = PW'(COORD_COUNT);
   localparam logic [PW-1:0] PH_WR_LAST = PW'(COORD_COUNT - 1);
   localparam logic [5:0]    SHIFT_MAX  = 6'(FRAC_BITS);

   localparam logic signed [DATA_WIDTH-1:0] ONE    = DATA_WIDTH'(64'd1 << FRAC_BITS);
   localparam logic signed [ACC_W-1:0]      SAT_HI = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [ACC_W-1:0]      SAT_LO = ~SAT_HI;

   typedef enum logic [2:0] {
      IDLE, RD_COUNT, RD_IDX, RD_NBR, RD_CUR, WRITE, DONE
   } state_t;

   state_t                  r_state, w_next;
   logic [PW-1:0]           r_ph;
   logic [ADDR_WIDTH-1:0]   r_vcount, r_v, r_k;
   logic [5:0]              r_shift;
   logic [NW-1:0]           r_n, r_j;
   logic                    r_ovf;
   logic signed [ACC_W-1:0] r_acc [COORD_COUNT];

   logic                     w_cnt_ovf;
   logic [NW-1:0]            w_cnt;
   logic [ADDR_WIDTH-1:0]    w_k;
   logic signed [DATA_WIDTH-1:0] w_weight;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_nterm, w_wterm, w_sel;

   function automatic logic [DATA_WIDTH-1:0] f_sat(input logic signed [ACC_W-1:0] a);
      if (a > SAT_HI)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (a < SAT_LO) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                 return a[DATA_WIDTH-1:0];
   endfunction

   assign w_cnt_ovf = RAM_NBR_Do > DATA_WIDTH'(MAX_NEIGHBOR_COUNT - 1);
   assign w_cnt     = w_cnt_ovf ? N_CAP : RAM_NBR_Do[NW-1:0];
   // The index word arrives in phase 0, so it is used directly there and held in r_k afterwards.
   assign w_k       = (r_ph == '0) ? RAM_NBR_Do[ADDR_WIDTH-1:0] : r_k;
   assign w_weight  = ONE - $signed((DATA_WIDTH'(r_n) << FRAC_BITS) >> r_shift);
   assign w_prod    = PROD_W'($signed(RAM_OBJ_Do)) * PROD_W'(w_weight);
   assign w_wterm   = ACC_W'(w_prod >>> FRAC_BITS);
   assign w_nterm   = ACC_W'($signed(RAM_OBJ_Do) >>> r_shift);
   assign err_nbr_ovf = r_ovf;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Select the accumulator for the coordinate being written.
   always_comb begin
      w_sel = r_acc[0];
      for (int c = 0; c < COORD_COUNT; c++)
         if (r_ph == PW'(c)) w_sel = r_acc[c];
   end

   // Next-state logic and RAM/status outputs.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_next     = r_state;
      RAM_OBJ_EN = 1'b0;
      RAM_OBJ_A  = '0;
      RAM_NBR_EN = 1'b0;
      RAM_NBR_A  = '0;
      RAM_RES_EN = 1'b0;
      RAM_RES_WE = 4'b0000;
      RAM_RES_A  = '0;
      RAM_RES_Di = '0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = (vertex_count == '0) ? DONE : RD_COUNT;
         end
         RD_COUNT: begin
            busy = 1'b1;
            if (r_ph == '0) begin
               RAM_NBR_EN = 1'b1;
               RAM_NBR_A  = ADDR_WIDTH'(r_v * MAX_NEIGHBOR_COUNT);
            end else begin
               w_next = (w_cnt == '0) ? RD_CUR : RD_IDX;
            end
         end
         RD_IDX: begin
            busy       = 1'b1;
            RAM_NBR_EN = 1'b1;
            RAM_NBR_A  = ADDR_WIDTH'(r_v * MAX_NEIGHBOR_COUNT + r_j);
            w_next     = RD_NBR;
         end
         RD_NBR: begin
            busy = 1'b1;
            if (r_ph < PH_LAST) begin
               RAM_OBJ_EN = 1'b1;
               RAM_OBJ_A  = ADDR_WIDTH'((w_k - 1) * COORD_COUNT + 1 + r_ph);
            end else begin
               w_next = (r_j == r_n) ? RD_CUR : RD_IDX;
            end
         end
         RD_CUR: begin
            busy = 1'b1;
            if (r_ph < PH_LAST) begin
               RAM_OBJ_EN = 1'b1;
               RAM_OBJ_A  = ADDR_WIDTH'(r_v * COORD_COUNT + 1 + r_ph);
            end else begin
               w_next = WRITE;
            end
         end
         WRITE: begin
            busy       = 1'b1;
            RAM_RES_EN = 1'b1;
            RAM_RES_WE = 4'b1111;
            RAM_RES_A  = ADDR_WIDTH'(r_v * COORD_COUNT + 1 + r_ph);
            RAM_RES_Di = f_sat(w_sel);
            if (r_ph == PH_WR_LAST)
               w_next = (r_v == r_vcount - ADDR_WIDTH'(1)) ? DONE : RD_COUNT;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Pass control: phase counter, pass parameters, vertex/neighbor counters, sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ph     <= '0;
         r_vcount <= '0;
         r_v      <= '0;
         r_k      <= '0;
         r_shift  <= '0;
         r_n      <= '0;
         r_j      <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_ph <= (w_next != r_state) ? '0 : r_ph + PW'(1);
         unique case (r_state)
            IDLE: if (start) begin
               r_vcount <= vertex_count;
               r_shift  <= ({2'b00, beta_shift} > SHIFT_MAX) ? SHIFT_MAX : {2'b00, beta_shift};
               r_v      <= '0;
               r_ovf    <= 1'b0;
            end
            RD_COUNT: if (r_ph != '0) begin
               r_n <= w_cnt;
               r_j <= NW'(1);
               if (w_cnt_ovf) r_ovf <= 1'b1;
            end
            RD_NBR: begin
               if (r_ph == '0)     r_k <= w_k;
               if (r_ph == PH_LAST) r_j <= r_j + NW'(1);
            end
            WRITE: if (r_ph == PH_WR_LAST) r_v <= r_v + ADDR_WIDTH'(1);
            default: ;
         endcase
      end
   end

   // Per-coordinate accumulators, one term per returning read word.
   // NOTE: accumulators are cleared in RD_COUNT before every use, so they carry no reset.
   always_ff @(posedge clk) begin
      for (int c = 0; c < COORD_COUNT; c++) begin
         if (r_state == RD_COUNT && r_ph != '0)
            r_acc[c] <= '0;
         else if (r_state == RD_NBR && r_ph == PW'(c + 1))
            r_acc[c] <= r_acc[c] + w_nterm;
         else if (r_state == RD_CUR && r_ph == PW'(c + 1))
            r_acc[c] <= r_acc[c] + w_wterm;
      end
   end

endmodule
